// File: rtl/meta_packet_gen_if.sv
// AXI-Stream style handshake bundle for the metadata packet generator output.
// The master drives data/valid/last; the slave returns ready.
interface meta_packet_gen_if #(
  parameter int unsigned DW = 128
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/meta_packet_gen.sv
// Metadata packet generator: one header beat plus cfg_len payload beats per packet,
// single-shot or back-to-back continuous, with full back-pressure and completion count.
module meta_packet_gen #(
  parameter int unsigned DW    = 128,
  parameter int unsigned LEN_W = 8,
  parameter logic [15:0] MAGIC = 16'h0666
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [7:0]           cfg_chan,
  input  logic                 cfg_continuous,
  meta_packet_gen_if.master    axis_out,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [15:0]          pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_cont;
  logic             r_stop;
  logic [LEN_W-1:0] r_idx;
  logic [15:0]      r_pkt_count;
  logic             r_done;
  logic             r_busy;
  logic             r_tvalid;
  logic             r_tlast;
  logic [DW-1:0]    r_tdata;

  logic             w_accept;
  logic [LEN_W-1:0] w_last_idx;
  logic [LEN_W-1:0] w_next_idx;
  logic             w_pkt_end;
  logic [15:0]      w_next_count;
  logic             w_stop_any;

  function automatic logic [DW-1:0] f_header(
    input logic [LEN_W-1:0] len,
    input logic [7:0]       chan,
    input logic [15:0]      seq
  );
    logic [DW-1:0] h;
    h            = '0;
    h[15:0]      = MAGIC;
    h[31:16]     = seq;
    h[39:32]     = chan;
    h[40 +: LEN_W] = len;
    return h;
  endfunction

  function automatic logic [DW-1:0] f_payload(
    input logic [LEN_W-1:0] idx,
    input logic [15:0]      seq
  );
    logic [DW-1:0] p;
    p              = '0;
    p[LEN_W-1:0]   = idx;
    p[31:16]       = seq;
    return p;
  endfunction

  assign w_accept     = r_tvalid & axis_out.tready;
  assign w_last_idx   = r_len - LEN_W'(1);
  assign w_next_idx   = r_idx + LEN_W'(1);
  assign w_next_count = r_pkt_count + 16'd1;
  assign w_stop_any   = r_stop | stop;
  assign w_pkt_end    = w_accept &
                        (((r_state == S_HDR) && (r_len == '0)) ||
                         ((r_state == S_PAY) && (r_idx == w_last_idx)));

  // Channel is not kept separately: the header is built straight from the
  // config inputs on HDR entry and held in r_tdata until accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cont      <= 1'b0;
      r_stop      <= 1'b0;
      r_idx       <= '0;
      r_pkt_count <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tdata     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stop <= 1'b0;
          if (start) begin
            r_len    <= cfg_len;
            r_cont   <= cfg_continuous;
            // stop coinciding with start suppresses continuous for this packet
            r_stop   <= stop;
            r_state  <= S_HDR;
            r_busy   <= 1'b1;
            r_tvalid <= 1'b1;
            r_tdata  <= f_header(cfg_len, cfg_chan, r_pkt_count);
            r_tlast  <= (cfg_len == '0);
          end
        end

        S_HDR, S_PAY: begin
          if (stop) begin
            r_stop <= 1'b1;
          end
          if (w_pkt_end) begin
            r_done      <= 1'b1;
            r_pkt_count <= w_next_count;
            r_idx       <= '0;
            if (r_cont && !w_stop_any) begin
              r_len   <= cfg_len;
              r_cont  <= cfg_continuous;
              r_stop  <= 1'b0;
              r_state <= S_HDR;
              r_tdata <= f_header(cfg_len, cfg_chan, w_next_count);
              r_tlast <= (cfg_len == '0);
            end else begin
              r_stop   <= 1'b0;
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_tdata  <= '0;
            end
          end else if (w_accept) begin
            if (r_state == S_HDR) begin
              r_state <= S_PAY;
              r_idx   <= '0;
              r_tdata <= f_payload('0, r_pkt_count);
              r_tlast <= (r_len == LEN_W'(1));
            end else begin
              r_idx   <= w_next_idx;
              r_tdata <= f_payload(w_next_idx, r_pkt_count);
              r_tlast <= (w_next_idx == w_last_idx);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign axis_out.tdata  = r_tdata;
  assign axis_out.tvalid = r_tvalid;
  assign axis_out.tlast  = r_tlast;
  assign busy            = r_busy;
  assign pkt_done        = r_done;
  assign pkt_count       = r_pkt_count;

endmodule
